// File: rtl/tx_pkg.sv
// Shared definitions for the 4x4 forward integer core transform.
// Holds the default element widths, the controller state encoding, the
// row-major element index helper and the derived intermediate widths.
package tx_pkg;

    localparam int DEF_IN_W  = 9;
    localparam int DEF_OUT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        COL  = 2'd2,
        DONE = 2'd3
    } tx_state_e;

    // Row-major element index: row*4 + col.
    function automatic logic [3:0] elem_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // Row pass grows by 3 bits, column pass by another 3.
    function automatic int row_w(input int in_w);
        return in_w + 3;
    endfunction

    function automatic int col_w(input int in_w);
        return in_w + 6;
    endfunction

endpackage

// File: rtl/fwd_tx_1d.sv
// Combinational 4-point forward core transform butterfly.
// Ports:
//   a_i : four signed W-bit inputs, element k at [k*W +: W]
//   y_o : four signed (W+3)-bit outputs, element k at [k*(W+3) +: W+3]
// Full precision: no truncation anywhere.
module fwd_tx_1d #(
    parameter int W = 15
) (
    input  logic [4*W-1:0]     a_i,
    output logic [4*(W+3)-1:0] y_o
);

    localparam int OW = W + 3;

    logic signed [OW-1:0] a0, a1, a2, a3;
    logic signed [OW-1:0] s0, s1, d0, d1;

    always_comb begin
        a0 = OW'($signed(a_i[0*W +: W]));
        a1 = OW'($signed(a_i[1*W +: W]));
        a2 = OW'($signed(a_i[2*W +: W]));
        a3 = OW'($signed(a_i[3*W +: W]));

        s0 = a0 + a3;
        s1 = a1 + a2;
        d0 = a0 - a3;
        d1 = a1 - a2;

        y_o = '0;
        y_o[0*OW +: OW] = s0 + s1;
        y_o[1*OW +: OW] = (d0 <<< 1) + d1;
        y_o[2*OW +: OW] = s0 - s1;
        y_o[3*OW +: OW] = d0 - (d1 <<< 1);
    end

endmodule

// File: rtl/int4x4_fwd_transform.sv
// 4x4 forward integer core transform Y = H*X*H^T using one shared
// butterfly: four row passes into T, then four column passes into Y.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   residual_in     : 16 signed IN_W elements, i = row*4+col
//   residual_valid  : input block valid
//   residual_ready  : block can accept input (IDLE only)
//   coeff_out       : 16 signed OUT_W coefficients, i = row*4+col
//   coeff_valid     : coeff_out valid (DONE only)
//   coeff_ready     : downstream accepts coeff_out
//
// state | meaning
// IDLE  | waiting for a residual block, residual_ready high
// ROW   | idx = row r, writes row r of T = X*H^T
// COL   | idx = col c, writes column c of Y = H*T
// DONE  | coeff_valid high, coeff_out held until coeff_ready
module int4x4_fwd_transform
    import tx_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16*IN_W-1:0]   residual_in,
    input  logic                 residual_valid,
    output logic                 residual_ready,
    output logic [16*OUT_W-1:0]  coeff_out,
    output logic                 coeff_valid,
    input  logic                 coeff_ready
);

    localparam int ROW_W = row_w(IN_W);
    localparam int COL_W = col_w(IN_W);
    localparam int BF_W  = COL_W + 3;

    if (OUT_W < COL_W) begin : g_bad_out_w
        $error("int4x4_fwd_transform: OUT_W must be at least IN_W+6");
    end

    tx_state_e            state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [16*IN_W-1:0]   x_q;
    logic [16*ROW_W-1:0]  t_q;
    logic [16*OUT_W-1:0]  coeff_q;
    logic [4*COL_W-1:0]   bf_a;
    logic [4*BF_W-1:0]    bf_y;
    logic [11:0]          unused_bf_hi;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (residual_valid) begin
                    state_d = ROW;
                    idx_d   = 2'd0;
                end
            end
            ROW: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = COL;
            end
            COL: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                if (coeff_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The butterfly runs at column width; row operands are sign-extended.
    always_comb begin
        bf_a = '0;
        for (int k = 0; k < 4; k++) begin
            if (state_q == COL)
                bf_a[k*COL_W +: COL_W] =
                    COL_W'($signed(t_q[elem_idx(2'(k), idx_q)*ROW_W +: ROW_W]));
            else
                bf_a[k*COL_W +: COL_W] =
                    COL_W'($signed(x_q[elem_idx(idx_q, 2'(k))*IN_W +: IN_W]));
        end
    end

    fwd_tx_1d #(.W(COL_W)) u_bf (
        .a_i (bf_a),
        .y_o (bf_y)
    );

    // Top three butterfly bits never carry magnitude for in-range data.
    for (genvar k = 0; k < 4; k++) begin : g_unused
        assign unused_bf_hi[k*3 +: 3] = bf_y[k*BF_W + COL_W +: 3];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            x_q     <= '0;
            t_q     <= '0;
            coeff_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == IDLE && residual_valid)
                x_q <= residual_in;
            if (state_q == ROW)
                for (int k = 0; k < 4; k++)
                    t_q[elem_idx(idx_q, 2'(k))*ROW_W +: ROW_W] <= bf_y[k*BF_W +: ROW_W];
            if (state_q == COL)
                for (int k = 0; k < 4; k++)
                    coeff_q[elem_idx(2'(k), idx_q)*OUT_W +: OUT_W] <=
                        OUT_W'($signed(bf_y[k*BF_W +: COL_W]));
        end
    end

    assign residual_ready = (state_q == IDLE);
    assign coeff_valid    = (state_q == DONE);
    assign coeff_out      = coeff_q;

endmodule

// File: doc/int4x4_fwd_transform.md
Name: int4x4_fwd_transform

Overview:
Downstream stage of the intra DC predictor. Accepts one 4x4 block of signed 9-bit residuals and computes the H.264 4x4 forward integer core transform Y = H·X·Hᵀ, with H = [[1,1,1,1],[2,1,-1,-2],[1,-1,-1,1],[1,-2,2,-1]]. It uses one shared 1-D butterfly: four row passes, then four column passes. Output goes to the quantiser under a valid/ready handshake. No scaling or quantisation is done here.

Parameters:
IN_W, 9, signed residual element width.
OUT_W, 16, signed coefficient element width. Must be ≥ IN_W+6; elaboration error otherwise.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
residual_in  in  16*IN_W  element i = row*4+col at [i*IN_W +: IN_W], two's complement
residual_valid  in  1  residual_in valid
residual_ready  out  1  block can accept input
coeff_out  out  16*OUT_W  Y element i = row*4+col at [i*OUT_W +: OUT_W], signed
coeff_valid  out  1  coeff_out valid
coeff_ready  in  1  downstream accepts coeff_out

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE, residual_ready=1, coeff_valid=0, coeff_out=0, all internal row/col storage=0.
- FSM states:
  - IDLE: residual_ready=1. On residual_valid&&residual_ready, capture residual_in, set r=0, go to ROW.
  - ROW: 4 cycles, r=0..3. Each edge writes row r of T = X·Hᵀ (element width IN_W+3) into storage. At r=3, go to COL with c=0.
  - COL: 4 cycles, c=0..3. Each edge writes column c of Y = H·T into coeff_out, sign-extended to OUT_W. At c=3, go to DONE and set coeff_valid=1.
  - DONE: coeff_valid=1 and coeff_out held stable. On coeff_ready, clear coeff_valid and go to IDLE.
- Latency: capture edge = E0. coeff_valid rises after E8 and is visible in the cycle following E8. Minimum spacing between accepts is 10 cycles; there is no overlap between blocks.
- residual_ready=0 in ROW, COL and DONE. residual_valid in those states is ignored, and no data is captured.
- 1-D butterfly (combinational), for inputs a0..a3:
  - s0=a0+a3, s1=a1+a2, d0=a0-a3, d1=a1-a2.
  - y0=s0+s1, y1=2·d0+d1, y2=s0-s1, y3=d0-2·d1.
  - Full precision, no truncation. Row pass output is IN_W+3 bits; column pass output is IN_W+6 bits.
- coeff_out bits of columns not yet written during COL are don't-care until coeff_valid; the bench checks only when valid.
- coeff_ready is ignored outside DONE.
- If coeff_ready is already high when DONE is entered, the handshake completes on the first DONE edge. coeff_valid is high for exactly one cycle.
- rst asserted in any state aborts immediately to reset values. A partially transformed block is discarded and never emitted.

Decomposition:
- Shared package tx_pkg:
  - IN_W/OUT_W defaults.
  - State enum {IDLE, ROW, COL, DONE}.
  - Element index helper (row*4+col).
  - Derived widths ROW_W=IN_W+3 and COL_W=IN_W+6.
- Sub-module fwd_tx_1d: combinational 4-point butterfly, parameterised on input width, output width = input+3.
  - Instantiated once at the widest width (COL_W inputs, row inputs sign-extended).
  - Muxed between row and column operands.

Test Plan:
- All-zero block → coeff_out all 0; coeff_valid first high in the cycle after E8.
- All elements +1 → Y[0]=16, the other 15 = 0. All elements -255 → Y[0]=-4080, others 0.
- Impulse X[0][0]=1, others 0 → Y rows [1,2,1,1], [2,4,2,2], [1,2,1,1], [1,2,1,1].
- Worst case X[i][j]=255·s[i]·s[j], s=[+1,+1,-1,-1] → Y[1][1]=9180. Check every element against a bit-accurate model; no overflow.
- Hold coeff_ready=0 for 5 cycles in DONE, with residual_valid=1 and new data throughout:
  - coeff_out stable and residual_ready=0 throughout.
  - The new block is accepted only in the cycle after the coeff handshake.
- Assert rst during COL c=2 → coeff_valid stays 0 and residual_ready=1 immediately. A following block transforms correctly with no stale data.
